// File: rtl/bin_to_bcd8_if.sv
// Handshake and digit bus between the binary-to-BCD converter and its users.
//   Start/Value      : request and operand (master -> slave)
//   Ready/Done       : idle flag and one-cycle completion pulse (slave -> master)
//   Overflow         : last committed operand exceeded eight decimal digits
//   BCD7..BCD0       : 6-bit digit codes for the seven-segment driver, MSD first
interface bin_to_bcd8_if #(
    parameter int IN_W = 27
);
    logic            Start;
    logic [IN_W-1:0] Value;
    logic            Ready;
    logic            Done;
    logic            Overflow;
    logic [5:0]      BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0;

    modport master (
        output Start, Value,
        input  Ready, Done, Overflow,
        input  BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0
    );

    modport slave (
        input  Start, Value,
        output Ready, Done, Overflow,
        output BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0
    );
endinterface

// File: rtl/bin_to_bcd8.sv
// Sequential binary-to-BCD converter (shift-add-3, one operand bit per clock)
// feeding an 8-digit seven-segment driver. Digit outputs are held registers
// updated only at commit, so a partially converted value is never displayed.
// Ports:
//   Clk    : system clock
//   Reset  : synchronous, active-high; aborts any running conversion
//   bus    : slave side of bin_to_bcd8_if (Start/Value in; Ready, Done,
//            Overflow, BCD7..BCD0 out)
module bin_to_bcd8 #(
    parameter int          IN_W       = 27,
    parameter bit          BLANK_LZ   = 1'b1,
    parameter logic [5:0]  BLANK_CODE = 6'd63
) (
    input  logic           Clk,
    input  logic           Reset,
    bin_to_bcd8_if.slave   bus
);
    localparam int         CNT_W    = $clog2(IN_W);
    localparam logic [5:0] RST_FILL = BLANK_LZ ? BLANK_CODE : 6'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [IN_W-1:0]       operand;
    logic [31:0]           scratch, adj;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf_pend;
    logic                  done_q;
    logic                  ovf_q;
    logic [7:0][5:0]       dig_q, commit_dig;
    logic                  lead;
    logic [3:0]            nib;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = SHIFT;
            SHIFT:   if (cnt == CNT_W'(IN_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would reach 10 or more after doubling
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 8; i++)
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end

    // Digit codes to commit: overflow forces all 9s (never blanked); otherwise
    // zeros above the most significant nonzero digit are blanked, BCD0 always shown.
    always_comb begin
        lead       = BLANK_LZ;
        nib        = 4'd0;
        commit_dig = '0;
        for (int i = 7; i >= 0; i--) begin
            nib = scratch[4*i +: 4];
            if (ovf_pend) begin
                commit_dig[i] = 6'd9;
            end else if (lead && (i != 0) && (nib == 4'd0)) begin
                commit_dig[i] = BLANK_CODE;
            end else begin
                commit_dig[i] = {2'b00, nib};
                lead          = 1'b0;
            end
        end
    end

    // Datapath
    always_ff @(posedge Clk) begin
        if (Reset) begin
            operand  <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dig_q    <= {{7{RST_FILL}}, 6'd0};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.Start) begin
                    operand  <= bus.Value;
                    ovf_pend <= 64'(bus.Value) > 64'd99_999_999;
                    scratch  <= '0;
                    cnt      <= '0;
                end
                SHIFT: begin
                    scratch <= {adj[30:0], operand[IN_W-1]};
                    operand <= operand << 1;
                    cnt     <= cnt + 1'b1;
                end
                COMMIT: begin
                    dig_q  <= commit_dig;
                    ovf_q  <= ovf_pend;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Ready    = (state_q == IDLE);
    assign bus.Done     = done_q;
    assign bus.Overflow = ovf_q;
    assign bus.BCD7     = dig_q[7];
    assign bus.BCD6     = dig_q[6];
    assign bus.BCD5     = dig_q[5];
    assign bus.BCD4     = dig_q[4];
    assign bus.BCD3     = dig_q[3];
    assign bus.BCD2     = dig_q[2];
    assign bus.BCD1     = dig_q[1];
    assign bus.BCD0     = dig_q[0];
endmodule

// File: tb/tb_bin_to_bcd8.sv
// Directed bench for bin_to_bcd8. Two instances share Start/Value/Reset:
// dut_a blanks leading zeros, dut_b shows all zeros.
module tb_bin_to_bcd8;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    bin_to_bcd8_if #(.IN_W(27)) a ();
    bin_to_bcd8_if #(.IN_W(27)) b ();
    assign b.Start = a.Start;
    assign b.Value = a.Value;

    bin_to_bcd8 #(.IN_W(27), .BLANK_LZ(1'b1), .BLANK_CODE(6'd63)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(a));
    bin_to_bcd8 #(.IN_W(27), .BLANK_LZ(1'b0), .BLANK_CODE(6'd63)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(b));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc, dones, done_at;

    // Expected digit vector, BCD7 first; -1 stands for a blanked digit.
    function automatic logic [47:0] d8(input int d7, d6, d5, d4, d3, d2, d1, d0);
        int d [8];
        logic [47:0] r;
        d = '{d0, d1, d2, d3, d4, d5, d6, d7};
        r = '0;
        for (int i = 0; i < 8; i++) r[6*i +: 6] = (d[i] < 0) ? 6'd63 : 6'(d[i]);
        return r;
    endfunction

    function automatic logic [47:0] dig_a();
        return {a.BCD7, a.BCD6, a.BCD5, a.BCD4, a.BCD3, a.BCD2, a.BCD1, a.BCD0};
    endfunction

    function automatic logic [47:0] dig_b();
        return {b.BCD7, b.BCD6, b.BCD5, b.BCD4, b.BCD3, b.BCD2, b.BCD1, b.BCD0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and record Done pulses.
    task automatic step();
        @(posedge Clk);
        #1;
        cyc++;
        if (a.Done) begin
            dones++;
            done_at = cyc;
        end
    endtask

    // Accept v on the first edge, then wait (bounded) for Done.
    task automatic conv(input int v);
        cyc = 0; dones = 0; done_at = 0;
        a.Value = 27'(v);
        a.Start = 1'b1;
        step();
        a.Start = 1'b0;
        while (dones == 0 && cyc < 100) step();
        check("latency", 64'(done_at), 64'd29);
    endtask

    initial begin
        Reset   = 1'b1;
        a.Start = 1'b0;
        a.Value = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("rst_ready", 64'(a.Ready), 64'd1);
        check("rst_done", 64'(a.Done), 64'd0);
        check("rst_ovf", 64'(a.Overflow), 64'd0);
        check("rst_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, -1, 0)));
        check("rst_dig_b", 64'(dig_b()), 64'(d8(0, 0, 0, 0, 0, 0, 0, 0)));

        conv(0);
        check("zero_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, -1, 0)));
        check("zero_ovf", 64'(a.Overflow), 64'd0);
        step();
        check("done_one_cycle", 64'(a.Done), 64'd0);

        conv(12_345_678);
        check("seq_dig_a", 64'(dig_a()), 64'(d8(1, 2, 3, 4, 5, 6, 7, 8)));
        check("seq_ovf", 64'(a.Overflow), 64'd0);

        conv(99_999_999);
        check("max_dig_a", 64'(dig_a()), 64'(d8(9, 9, 9, 9, 9, 9, 9, 9)));
        check("max_ovf", 64'(a.Overflow), 64'd0);

        conv(100_000_000);
        check("ovf_dig_a", 64'(dig_a()), 64'(d8(9, 9, 9, 9, 9, 9, 9, 9)));
        check("ovf_flag", 64'(a.Overflow), 64'd1);
        step();
        check("ovf_held", 64'(a.Overflow), 64'd1);

        conv(5);
        check("five_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, -1, 5)));
        check("five_dig_b", 64'(dig_b()), 64'(d8(0, 0, 0, 0, 0, 0, 0, 5)));
        check("five_ovf", 64'(a.Overflow), 64'd0);

        // Busy Start ignored, then Start held through Done -> back-to-back accept
        cyc = 0; dones = 0; done_at = 0;
        a.Value = 27'd42; a.Start = 1'b1;
        step();
        a.Start = 1'b0;
        check("busy_ready", 64'(a.Ready), 64'd0);
        repeat (8) step();
        a.Value = 27'd7; a.Start = 1'b1;
        step();
        a.Start = 1'b0;
        repeat (16) step();
        a.Value = 27'd8; a.Start = 1'b1;
        repeat (3) step();
        check("busy_dones", 64'(dones), 64'd1);
        check("busy_done_at", 64'(done_at), 64'd29);
        check("busy_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, 4, 2)));
        step();
        a.Start = 1'b0;
        check("b2b_ready", 64'(a.Ready), 64'd0);
        check("b2b_done", 64'(a.Done), 64'd0);
        while (dones < 2 && cyc < 120) step();
        check("b2b_done_at", 64'(done_at), 64'd58);
        check("b2b_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, -1, 8)));

        // Reset mid-conversion
        cyc = 0; dones = 0; done_at = 0;
        a.Value = 27'd87_654_321; a.Start = 1'b1;
        step();
        a.Start = 1'b0;
        repeat (13) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid_rst_ready", 64'(a.Ready), 64'd1);
        check("mid_rst_done", 64'(a.Done), 64'd0);
        check("mid_rst_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, -1, 0)));
        repeat (40) step();
        check("mid_rst_no_done", 64'(dones), 64'd0);
        conv(3);
        check("after_rst_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, -1, -1, 3)));

        // No-blanking instance, digits held during the next conversion
        conv(907);
        check("n907_dig_b", 64'(dig_b()), 64'(d8(0, 0, 0, 0, 0, 9, 0, 7)));
        check("n907_dig_a", 64'(dig_a()), 64'(d8(-1, -1, -1, -1, -1, 9, 0, 7)));
        cyc = 0; dones = 0; done_at = 0;
        a.Value = 27'd12; a.Start = 1'b1;
        step();
        a.Start = 1'b0;
        repeat (14) step();
        check("hold_dig_b", 64'(dig_b()), 64'(d8(0, 0, 0, 0, 0, 9, 0, 7)));
        while (dones == 0 && cyc < 100) step();
        check("n12_done_at", 64'(done_at), 64'd29);
        check("n12_dig_b", 64'(dig_b()), 64'(d8(0, 0, 0, 0, 0, 0, 1, 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
